// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the HI/LO multiply/divide sequencer.
//   DEFAULT_WIDTH - default operand / HI / LO width
//   OP_*          - 2-bit operation encodings carried on the op port
//   state_t       - sequencer state encoding
//   is_div / is_signed_op - decode helpers for the op field
package muldiv_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_RUN,
        S_FIXUP,
        S_DONE
    } state_t;

    function automatic logic is_div(input logic [1:0] op_v);
        return op_v[1];
    endfunction

    function automatic logic is_signed_op(input logic [1:0] op_v);
        return ~op_v[0];
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of the unsigned multiply/divide
// datapath on a 2*WIDTH accumulator.
//   div_mode - 0: shift-add multiply step, 1: restoring divide step
//   acc      - current accumulator
//              multiply: {partial product high, multiplier bits still to consume}
//              divide:   {partial remainder, dividend bits / quotient bits}
//   operand  - multiplicand (multiply) or divisor (divide) magnitude
//   next_acc - accumulator after this iteration
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 div_mode,
    input  logic [2*WIDTH-1:0]   acc,
    input  logic [WIDTH-1:0]     operand,
    output logic [2*WIDTH-1:0]   next_acc
);

    logic [WIDTH:0]   mul_sum;
    // Partial remainder after the left shift needs WIDTH+1 bits, since the
    // remainder before the shift may be as large as divisor-1.
    logic [WIDTH:0]   rem_shifted;
    logic             rem_ge;
    logic [WIDTH-1:0] rem_diff;

    always_comb begin
        mul_sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
        rem_shifted = acc[2*WIDTH-1:WIDTH-1];
        rem_ge      = rem_shifted >= {1'b0, operand};
        // When no borrow occurs the difference is below the divisor, so it fits in WIDTH bits.
        rem_diff    = WIDTH'(rem_shifted - {1'b0, operand});

        next_acc = '0;
        if (!div_mode) begin
            next_acc = {mul_sum, acc[WIDTH-1:1]};
        end else if (rem_ge) begin
            next_acc = {rem_diff, acc[WIDTH-2:0], 1'b1};
        end else begin
            next_acc = {rem_shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: multi-cycle MULT/MULTU/DIV/DIVU sequencer for the EX stage,
// owner of the HI/LO registers.
//   clk, reset     - rising-edge clock, asynchronous active-high reset
//   start, op, a, b - launch an operation (accepted only in IDLE)
//   flush          - squash the in-flight operation; HI/LO untouched
//   hi_we, lo_we, wdata - MTHI/MTLO writes (honoured only in IDLE)
//   rd_req         - MFHI/MFLO in EX this cycle
//   busy           - operation in flight (any state but IDLE)
//   done           - one-cycle pulse in the cycle after HI/LO are written
//   stall          - rd_req while busy
//   hi, lo         - HI/LO registers
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd_req,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t             state;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   a_q;        // original operands, kept for divide-by-zero
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   opnd_q;     // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0] acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               sign_q;     // product / quotient sign
    logic               sign_r_q;   // remainder sign
    logic               done_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic               div_by_zero;

    muldiv_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .div_mode (is_div(op_q)),
        .acc      (acc_q),
        .operand  (opnd_q),
        .next_acc (acc_next)
    );

    always_comb begin
        // The most negative value negates to itself, which is the correct magnitude when read unsigned.
        mag_a = (is_signed_op(op_q) && a_q[WIDTH-1]) ? -a_q : a_q;
        mag_b = (is_signed_op(op_q) && b_q[WIDTH-1]) ? -b_q : b_q;

        prod_fix = sign_q   ? -acc_q : acc_q;
        quot_fix = sign_q   ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = sign_r_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

        div_by_zero = is_div(op_q) && (b_q == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
            sign_r_q <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            done_q <= 1'b0;
            if (state != S_IDLE && flush) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (hi_we) hi_q <= wdata;
                        if (lo_we) lo_q <= wdata;
                        if (start && !flush) begin
                            op_q     <= op;
                            a_q      <= a;
                            b_q      <= b;
                            sign_q   <= is_signed_op(op) & (a[WIDTH-1] ^ b[WIDTH-1]);
                            sign_r_q <= is_signed_op(op) & is_div(op) & a[WIDTH-1];
                            state    <= S_PREP;
                        end
                    end
                    S_PREP: begin
                        // Multiply consumes the multiplier from the low half; divide shifts the dividend up out of it.
                        if (is_div(op_q)) begin
                            acc_q  <= {{WIDTH{1'b0}}, mag_a};
                            opnd_q <= mag_b;
                        end else begin
                            acc_q  <= {{WIDTH{1'b0}}, mag_b};
                            opnd_q <= mag_a;
                        end
                        cnt_q <= '0;
                        state <= S_RUN;
                    end
                    S_RUN: begin
                        acc_q <= acc_next;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(WIDTH - 1)) begin
                            state <= S_FIXUP;
                        end
                    end
                    S_FIXUP: begin
                        if (!is_div(op_q)) begin
                            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                            lo_q <= prod_fix[WIDTH-1:0];
                        end else if (div_by_zero) begin
                            hi_q <= a_q;
                            lo_q <= '1;
                        end else begin
                            hi_q <= rem_fix;
                            lo_q <= quot_fix;
                        end
                        done_q <= 1'b1;
                        state  <= S_DONE;
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign busy  = (state != S_IDLE);
    assign stall = rd_req & busy;
    assign done  = done_q;
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
module tb_muldiv_ctrl;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         flush;
    logic         hi_we;
    logic         lo_we;
    logic [W-1:0] wdata;
    logic         rd_req;
    logic         busy;
    logic         done;
    logic         stall;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    bit cmp_en = 1'b0;

    muldiv_ctrl #(
        .WIDTH(W),
        .CNT_W(6)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .flush  (flush),
        .hi_we  (hi_we),
        .lo_we  (lo_we),
        .wdata  (wdata),
        .rd_req (rd_req),
        .busy   (busy),
        .done   (done),
        .stall  (stall),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result {hi, lo} from plain integer arithmetic.
    function automatic logic [63:0] model_result(input logic [1:0] o, input logic [31:0] x,
                                                 input logic [31:0] y);
        logic signed [31:0] sx;
        logic signed [31:0] sy;
        logic signed [63:0] sp;
        sx = x;
        sy = y;
        case (o)
            OP_MULT: begin
                sp = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
                return sp;
            end
            OP_MULTU: return {32'h0, x} * {32'h0, y};
            OP_DIV: begin
                if (y == 32'h0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                return {32'(sx % sy), 32'(sx / sy)};
            end
            default: begin
                if (y == 32'h0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
        endcase
    endfunction

    // Behavioural model: phase counts cycles since the accepting edge
    // (0 = idle, result visible after phase 34, phase 35 = done cycle).
    int           m_phase;
    logic [W-1:0] m_hi;
    logic [W-1:0] m_lo;
    logic [W-1:0] m_rhi;
    logic [W-1:0] m_rlo;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase <= 0;
            m_hi    <= '0;
            m_lo    <= '0;
        end else if (m_phase == 0) begin
            if (hi_we) m_hi <= wdata;
            if (lo_we) m_lo <= wdata;
            if (start && !flush) begin
                {m_rhi, m_rlo} <= model_result(op, a, b);
                m_phase <= 1;
            end
        end else if (flush) begin
            m_phase <= 0;
        end else if (m_phase == 34) begin
            m_hi    <= m_rhi;
            m_lo    <= m_rlo;
            m_phase <= 35;
        end else if (m_phase == 35) begin
            m_phase <= 0;
        end else begin
            m_phase <= m_phase + 1;
        end
    end

    always @(negedge clk) begin
        if (cmp_en && !reset) begin
            chk("busy",  busy,  m_phase != 0);
            chk("done",  done,  m_phase == 35);
            chk("stall", stall, rd_req && (m_phase != 0));
            chk("hi",    hi,    m_hi);
            chk("lo",    lo,    m_lo);
            if (done) done_cnt++;
        end
    end

    // One operation with literal expectations; poke_at != 0 injects a start
    // and an MTHI write while busy at that cycle offset.
    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] xa,
                          input logic [31:0] xb, input logic [31:0] ehi, input logic [31:0] elo,
                          input int poke_at);
        int n;
        bit seen;
        int d0;
        @(posedge clk); #2;
        start = 1'b1; op = o; a = xa; b = xb;
        @(negedge clk);
        chk({name, " busy_before_accept"}, busy, 1'b0);
        chk({name, " stall_before_accept"}, stall, 1'b0);
        @(posedge clk); #2;
        start = 1'b0;
        d0 = done_cnt;
        n = 0;
        seen = 1'b0;
        while (n < 60 && !seen) begin
            @(negedge clk);
            n++;
            if (done) seen = 1'b1;
            if (poke_at != 0 && n == poke_at) begin
                start = 1'b1; op = OP_MULTU; a = $urandom; b = $urandom;
                hi_we = 1'b1; wdata = 32'h5555_5555;
            end
            if (poke_at != 0 && n == poke_at + 1) begin
                start = 1'b0; hi_we = 1'b0;
            end
        end
        chk({name, " done_seen"}, seen, 1'b1);
        chk({name, " latency"}, n, 35);
        chk({name, " hi"}, hi, ehi);
        chk({name, " lo"}, lo, elo);
        @(posedge clk); #2;
        @(negedge clk);
        chk({name, " idle_after"}, busy, 1'b0);
        chk({name, " stall_after"}, stall, 1'b0);
        chk({name, " one_done"}, done_cnt - d0, 1);
    endtask

    initial begin
        int d0;
        reset = 1'b1; start = 1'b0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        rd_req = 1'b0; op = '0; a = '0; b = '0; wdata = '0;
        #1;
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset hi", hi, 32'h0);
        chk("reset lo", lo, 32'h0);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        cmp_en = 1'b1;

        run_op("mult_neg",   OP_MULT,  32'hFFFF_FFFD, 32'h7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
        run_op("multu_max",  OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0);
        run_op("divu",       OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        0);
        run_op("div_neg",    OP_DIV,   32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
        run_op("div_ovf",    OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 0);
        run_op("divu_zero",  OP_DIVU,  32'h1234_5678, 32'h0,         32'h1234_5678, 32'hFFFF_FFFF, 5);
        rd_req = 1'b1;
        run_op("div_zero_s", OP_DIV,   32'hFFFF_FFF0, 32'h0,         32'hFFFF_FFF0, 32'hFFFF_FFFF, 0);
        rd_req = 1'b0;

        // Flush mid-operation keeps a preloaded HI and produces no done.
        @(posedge clk); #2;
        hi_we = 1'b1; wdata = 32'h0000_AAAA;
        @(posedge clk); #2;
        hi_we = 1'b0; start = 1'b1; op = OP_MULT; a = 32'h0001_0003; b = 32'h0002_0005;
        @(posedge clk); #2;
        start = 1'b0;
        d0 = done_cnt;
        repeat (9) @(posedge clk);
        #2;
        flush = 1'b1;
        @(posedge clk); #2;
        flush = 1'b0;
        chk("flush busy", busy, 1'b0);
        repeat (40) @(posedge clk);
        #2;
        chk("flush no_done", done_cnt - d0, 0);
        chk("flush hi", hi, 32'h0000_AAAA);

        // Asynchronous reset in the middle of RUN.
        @(posedge clk); #2;
        start = 1'b1; op = OP_DIVU; a = 32'hDEAD_BEEF; b = 32'h0000_0123;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #3;
        chk("pre_reset busy", busy, 1'b1);
        reset = 1'b1;
        #1;
        chk("async_reset busy", busy, 1'b0);
        chk("async_reset hi", hi, 32'h0);
        chk("async_reset lo", lo, 32'h0);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;

        // Randomized traffic; the compare process checks every cycle.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #2;
            start  = ($urandom % 4) == 0;
            op     = 2'($urandom);
            a      = ($urandom % 8 == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom % 8)
                0:       b = 32'h0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = 32'($urandom % 16);
                default: b = $urandom;
            endcase
            flush  = ($urandom % 150) == 0;
            hi_we  = ($urandom % 8) == 0;
            lo_we  = ($urandom % 8) == 0;
            wdata  = $urandom;
            rd_req = $urandom % 2;
        end
        @(posedge clk); #2;
        start = 1'b0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0; rd_req = 1'b0;
        repeat (40) @(posedge clk);
        #2;
        chk("final idle", busy, 1'b0);

        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
